// File: rtl/clock_div_sched.sv
// Runtime-programmable clock divider; ratio changes land only on a period boundary. Optional period counter: CLK_DIV_SCHED_PCNT_EN.
// Latency: clk_out/tick rise the cycle after a start accept; a change applies at the next boundary. Backpressure: req_ready low while a change is pending.
module clock_div_sched #(
    parameter int DIV_W  = 8,
    parameter int PCNT_W = 16
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [DIV_W-1:0]  req_div,
    output logic              req_ready,
    output logic              req_err,
    output logic              clk_out,
    output logic              tick,
    output logic              busy,
    output logic [DIV_W-1:0]  active_div,
    output logic [PCNT_W-1:0] period_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_SWITCH = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [DIV_W-1:0] r_cnt, w_cnt_nxt;
    logic [DIV_W-1:0] r_pend, w_pend_nxt;
    logic [DIV_W-1:0] r_active_div, w_active_nxt;
    logic             r_clk_out, w_clk_nxt;
    logic             r_tick, w_tick_nxt;
    logic             r_req_err, w_err_nxt;
    logic             w_busy;
    logic             w_accept;
    logic             w_wrap;
    logic             w_req_bad;
    logic             w_req_stop;

    assign w_busy     = (r_state == S_RUN) || (r_state == S_SWITCH);
    assign req_ready  = (r_state != S_SWITCH);
    assign busy       = w_busy;
    assign w_accept   = req_valid && req_ready;
    assign w_req_bad  = (req_div == DIV_W'(1));
    assign w_req_stop = (req_div == '0);
    assign w_wrap     = w_busy && (r_cnt == r_active_div - DIV_W'(1));

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_pend_nxt   = r_pend;
        w_active_nxt = r_active_div;
        w_clk_nxt    = r_clk_out;
        w_tick_nxt   = 1'b0;
        w_err_nxt    = 1'b0;

        // The old ratio keeps counting in SWITCH; only the boundary edge below may override it.
        if (w_busy) begin
            w_cnt_nxt  = w_wrap ? '0 : r_cnt + DIV_W'(1);
            w_clk_nxt  = (w_cnt_nxt < (r_active_div >> 1));
            w_tick_nxt = w_wrap;
        end

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_req_bad) begin
                        w_err_nxt = 1'b1;
                    end else if (!w_req_stop) begin
                        w_active_nxt = req_div;
                        w_cnt_nxt    = '0;
                        w_clk_nxt    = 1'b1;
                        w_tick_nxt   = 1'b1;
                        w_state_nxt  = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (w_accept) begin
                    if (w_req_bad) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_pend_nxt  = req_div;
                        w_state_nxt = S_SWITCH;
                    end
                end
            end
            S_SWITCH: begin
                if (w_wrap) begin
                    w_cnt_nxt = '0;
                    if (r_pend == '0) begin
                        w_active_nxt = '0;
                        w_clk_nxt    = 1'b0;
                        w_tick_nxt   = 1'b0;
                        w_state_nxt  = S_IDLE;
                    end else begin
                        w_active_nxt = r_pend;
                        w_clk_nxt    = 1'b1;
                        w_tick_nxt   = 1'b1;
                        w_state_nxt  = S_RUN;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_pend       <= '0;
            r_active_div <= '0;
            r_clk_out    <= 1'b0;
            r_tick       <= 1'b0;
            r_req_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_pend       <= w_pend_nxt;
            r_active_div <= w_active_nxt;
            r_clk_out    <= w_clk_nxt;
            r_tick       <= w_tick_nxt;
            r_req_err    <= w_err_nxt;
        end
    end

    assign clk_out    = r_clk_out;
    assign tick       = r_tick;
    assign req_err    = r_req_err;
    assign active_div = r_active_div;

`ifdef CLK_DIV_SCHED_PCNT_EN
    logic [PCNT_W-1:0] r_pcnt;

    // Survives a stop request; only reset clears it.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_pcnt <= '0;
        end else if (w_wrap) begin
            r_pcnt <= r_pcnt + PCNT_W'(1);
        end
    end

    assign period_count = r_pcnt;
`else
    assign period_count = '0;
`endif

endmodule

// File: tb/tb_clock_div_sched.sv
// Directed bench for clock_div_sched: start/stop, odd ratio, ratio switch, boundary coincidence, illegal ratio, async reset.
module tb_clock_div_sched;

`ifdef CLK_DIV_SCHED_PCNT_EN
    localparam bit PCNT_ON = 1'b1;
`else
    localparam bit PCNT_ON = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [7:0]  req_div;
    logic        req_ready;
    logic        req_err;
    logic        clk_out;
    logic        tick;
    logic        busy;
    logic [7:0]  active_div;
    logic [15:0] period_count;

    int n_cmp = 0;
    int n_err = 0;

    clock_div_sched #(.DIV_W(8), .PCNT_W(16)) dut (
        .clk_in       (clk_in),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_div      (req_div),
        .req_ready    (req_ready),
        .req_err      (req_err),
        .clk_out      (clk_out),
        .tick         (tick),
        .busy         (busy),
        .active_div   (active_div),
        .period_count (period_count)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic c, input logic t, input logic b,
                           input logic [7:0] a);
        chk({tag, ".clk_out"}, 32'(clk_out), 32'(c));
        chk({tag, ".tick"}, 32'(tick), 32'(t));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
        chk({tag, ".active_div"}, 32'(active_div), 32'(a));
    endtask

    task automatic chk_pcnt(input string tag, input int n);
        chk({tag, ".period_count"}, 32'(period_count), PCNT_ON ? 32'(n) : 32'd0);
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_div   = 8'd0;
        step();
        step();
        chk_out("reset", 1'b0, 1'b0, 1'b0, 8'd0);
        chk("reset.req_err", 32'(req_err), 32'd0);
        chk_pcnt("reset", 0);
        rst = 1'b0;
        step();
        chk("post_reset.req_ready", 32'(req_ready), 32'd1);

        // N=1 in IDLE is dropped with an error pulse
        req_valid = 1'b1; req_div = 8'd1;
        step();
        req_valid = 1'b0;
        chk("idle_n1.req_err", 32'(req_err), 32'd1);
        chk_out("idle_n1", 1'b0, 1'b0, 1'b0, 8'd0);
        step();
        chk("idle_n1_after.req_err", 32'(req_err), 32'd0);

        // N=4: 2 high, 2 low
        req_valid = 1'b1; req_div = 8'd4;
        step();
        req_valid = 1'b0;
        chk_out("n4_start", 1'b1, 1'b1, 1'b1, 8'd4);
        for (int i = 1; i <= 8; i++) begin
            step();
            chk_out($sformatf("n4_cyc%0d", i), ((i % 4) < 2), ((i % 4) == 0), 1'b1, 8'd4);
        end
        chk_pcnt("n4_two_periods", 2);

        // Stop: current period completes, then IDLE
        req_valid = 1'b1; req_div = 8'd0;
        step();
        req_valid = 1'b0;
        chk("stop_accept.req_ready", 32'(req_ready), 32'd0);
        chk_out("stop_cnt1", 1'b1, 1'b0, 1'b1, 8'd4);
        step();
        step();
        chk_out("stop_cnt3", 1'b0, 1'b0, 1'b1, 8'd4);
        step();
        chk_out("stopped", 1'b0, 1'b0, 1'b0, 8'd0);
        chk("stopped.req_ready", 32'(req_ready), 32'd1);
        chk_pcnt("stopped_keeps_count", 3);
        req_valid = 1'b1; req_div = 8'd0;
        step();
        req_valid = 1'b0;
        chk_out("idle_n0", 1'b0, 1'b0, 1'b0, 8'd0);
        chk("idle_n0.req_err", 32'(req_err), 32'd0);

        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_pcnt("rst_clears_count", 0);

        // N=5: pattern 1,1,0,0,0
        req_valid = 1'b1; req_div = 8'd5;
        step();
        req_valid = 1'b0;
        chk_out("n5_start", 1'b1, 1'b1, 1'b1, 8'd5);
        for (int i = 1; i <= 15; i++) begin
            step();
            chk_out($sformatf("n5_cyc%0d", i), ((i % 5) < 2), ((i % 5) == 0), 1'b1, 8'd5);
        end
        chk_pcnt("n5_three_periods", 3);

        // N=1 while running: error pulse, ratio unchanged
        req_valid = 1'b1; req_div = 8'd1;
        step();
        req_valid = 1'b0;
        chk("run_n1.req_err", 32'(req_err), 32'd1);
        chk("run_n1.req_ready", 32'(req_ready), 32'd1);
        chk_out("run_n1", 1'b1, 1'b0, 1'b1, 8'd5);
        step();
        chk("run_n1_after.req_err", 32'(req_err), 32'd0);

        // Change 5 -> 6 with cnt=2: new ratio after cnt 3,4
        req_valid = 1'b1; req_div = 8'd6;
        step();
        req_valid = 1'b0;
        chk("to6.req_ready", 32'(req_ready), 32'd0);
        chk_out("to6_cnt3", 1'b0, 1'b0, 1'b1, 8'd5);
        step();
        step();
        chk_out("n6_start", 1'b1, 1'b1, 1'b1, 8'd6);
        chk("n6_start.req_ready", 32'(req_ready), 32'd1);
        step();

        // Change 6 -> 3 requested at cnt=1
        req_valid = 1'b1; req_div = 8'd3;
        step();
        req_valid = 1'b0;
        chk_out("to3_cnt2", 1'b1, 1'b0, 1'b1, 8'd6);
        chk("to3_cnt2.req_ready", 32'(req_ready), 32'd0);
        for (int i = 3; i <= 5; i++) begin
            step();
            chk_out($sformatf("to3_cnt%0d", i), 1'b0, 1'b0, 1'b1, 8'd6);
            chk($sformatf("to3_cnt%0d.req_ready", i), 32'(req_ready), 32'd0);
        end
        step();
        chk_out("n3_start", 1'b1, 1'b1, 1'b1, 8'd3);
        chk("n3_start.req_ready", 32'(req_ready), 32'd1);
        step();
        chk_out("n3_cnt1", 1'b0, 1'b0, 1'b1, 8'd3);
        step();
        chk_out("n3_cnt2", 1'b0, 1'b0, 1'b1, 8'd3);

        // Accept coincident with a RUN boundary: old ratio wraps first
        req_valid = 1'b1; req_div = 8'd4;
        step();
        req_valid = 1'b0;
        chk_out("coinc_wrap", 1'b1, 1'b1, 1'b1, 8'd3);
        chk("coinc_wrap.req_ready", 32'(req_ready), 32'd0);
        step();
        step();
        chk_out("coinc_cnt2", 1'b0, 1'b0, 1'b1, 8'd3);
        step();
        chk_out("n4b_start", 1'b1, 1'b1, 1'b1, 8'd4);
        chk_pcnt("after_switches", 7);

        // Async reset while a change is pending, with clk_out high
        req_valid = 1'b1; req_div = 8'd2;
        step();
        req_valid = 1'b0;
        chk_out("sw_pending", 1'b1, 1'b0, 1'b1, 8'd4);
        rst = 1'b1;
        #1;
        chk_out("async_rst", 1'b0, 1'b0, 1'b0, 8'd0);
        chk("async_rst.req_err", 32'(req_err), 32'd0);
        chk_pcnt("async_rst", 0);
        step();
        rst = 1'b0;
        step();
        chk("rst_done.req_ready", 32'(req_ready), 32'd1);
        step();
        step();
        step();
        chk_out("pend_discarded", 1'b0, 1'b0, 1'b0, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
